// File: rtl/mul_pkg.sv
// Shared types for the multiplier start/done handshake: requester FSM states,
// multiplier controller states and default operand/product widths.
package mul_pkg;

  localparam int A_W_DEF = 4;
  localparam int P_W_DEF = 2 * A_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10,
    ST_HOLD   = 2'b11
  } req_state_t;

  // Shift-add multiplier controller states, kept beside the requester codes
  typedef enum logic [1:0] {
    MC_IDLE   = 2'b00,
    MC_RUN    = 2'b01,
    MC_FINISH = 2'b10
  } mc_state_t;

endpackage

// File: rtl/mul_req_fifo.sv
// Operand-pair buffer: synchronous FIFO with wrap-bit pointers and a
// combinational head so the requester can load operands in the pop cycle.
module mul_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still legal
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mul_requester.sv
// Initiator for the shift-add multiplier: buffers operand pairs, issues one job at a
// time with a start pulse, waits for done (or times out) and holds the result for pickup.
module mul_requester
  import mul_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int P_W        = 2 * A_W,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [A_W-1:0] in_b,
  output logic           mul_start,
  output logic [A_W-1:0] mul_a,
  output logic [A_W-1:0] mul_b,
  input  logic           mul_done,
  input  logic [P_W-1:0] mul_product,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [P_W-1:0] res_product,
  output logic           res_err,
  output logic           busy
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  req_state_t       state_q, state_d;
  logic [A_W-1:0]   mul_a_q, mul_a_d;
  logic [A_W-1:0]   mul_b_q, mul_b_d;
  logic [P_W-1:0]   res_product_q, res_product_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*A_W-1:0] fifo_head;
  logic             timed_out;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  mul_req_fifo #(
    .WIDTH (2 * A_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      res_product_q <= '0;
      res_err_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      res_product_q <= res_product_d;
      res_err_q     <= res_err_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (mul_done || timed_out) state_d = ST_HOLD;
      ST_HOLD:   if (res_ready) state_d = fifo_empty ? ST_IDLE : ST_LAUNCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_start     = (state_q == ST_LAUNCH);
    res_valid     = (state_q == ST_HOLD);
    busy          = (state_q != ST_IDLE) || !fifo_empty;
    fifo_pop      = !fifo_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready));
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    res_product_d = res_product_q;
    res_err_d     = res_err_q;
    cnt_d         = cnt_q;
    if (fifo_pop) begin
      mul_a_d = fifo_head[2*A_W-1:A_W];
      mul_b_d = fifo_head[A_W-1:0];
    end
    if (state_q == ST_LAUNCH) cnt_d = '0;
    if (state_q == ST_WAIT) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      // done takes priority over a coincident timeout
      if (mul_done) begin
        res_product_d = mul_product;
        res_err_d     = 1'b0;
      end else if (timed_out) begin
        res_product_d = '0;
        res_err_d     = 1'b1;
      end
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign res_product = res_product_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_mul_requester.sv
// Bench for mul_requester paired with a shift-add multiplier controller model;
// results are checked in order against a scoreboard filled when pairs are accepted.
module tb_mul_requester;
  import mul_pkg::*;

  localparam int A_W     = 4;
  localparam int P_W     = 8;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [A_W-1:0] in_a = '0;
  logic [A_W-1:0] in_b = '0;
  logic           mul_start;
  logic [A_W-1:0] mul_a, mul_b;
  logic           mul_done;
  logic [P_W-1:0] mul_product;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [P_W-1:0] res_product;
  logic           res_err;
  logic           busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic           err;
    logic [P_W-1:0] prod;
  } exp_t;
  exp_t sb[$];

  logic           mul_hang = 1'b0;
  logic           spur_done = 1'b0;
  logic           stall_seen = 1'b0;
  int             start_cnt = 0;
  logic           outstanding = 1'b0;
  logic           done_prev = 1'b0;
  logic [A_W-1:0] la, lb;

  always #5 clk = ~clk;

  mul_requester #(
    .A_W        (A_W),
    .P_W        (P_W),
    .FIFO_DEPTH (2),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
    .res_err     (res_err),
    .busy        (busy)
  );

  // Multiplier controller model: A_W run cycles, then one FINISH cycle with done
  mc_state_t      mc_state;
  int             mc_cnt;
  logic [P_W-1:0] mc_prod;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_state <= MC_IDLE;
      mc_cnt   <= 0;
      mc_prod  <= '0;
    end else begin
      case (mc_state)
        MC_IDLE: if (mul_start) begin
          mc_state <= MC_RUN;
          mc_cnt   <= 0;
        end
        MC_RUN: begin
          if (mc_cnt == A_W - 1) begin
            mc_state <= mul_hang ? MC_IDLE : MC_FINISH;
            mc_prod  <= {4'b0, mul_a} * {4'b0, mul_b};
          end else begin
            mc_cnt <= mc_cnt + 1;
          end
        end
        default: mc_state <= MC_IDLE;
      endcase
    end
  end

  assign mul_done    = (mc_state == MC_FINISH) | spur_done;
  assign mul_product = (mc_state == MC_FINISH) ? mc_prod : 8'hA5;

  // Monitor: one-job-at-a-time, operand stability, done->valid latency, scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (mul_start) begin
        start_cnt++;
        checks++;
        if (outstanding) begin
          failures++;
          $display("FAIL overlap_start: got mul_start with job outstanding, required none");
        end
        outstanding = 1'b1;
        la = mul_a;
        lb = mul_b;
      end else if (outstanding && !res_valid) begin
        checks++;
        if (mul_a !== la || mul_b !== lb) begin
          failures++;
          $display("FAIL operand_stable: got a=%0d b=%0d required a=%0d b=%0d", mul_a, mul_b, la, lb);
        end
      end
      if (done_prev) begin
        checks++;
        if (res_valid !== 1'b1) begin
          failures++;
          $display("FAIL done_to_valid: got res_valid=%b required 1", res_valid);
        end
      end
      done_prev = (mc_state == MC_FINISH);
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got product=%0d err=%b with empty scoreboard", res_product, res_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (res_product !== e.prod || res_err !== e.err) begin
            failures++;
            $display("FAIL result: got product=%0d err=%b required product=%0d err=%b", res_product, res_err, e.prod, e.err);
          end else begin
            $display("result product=%0d err=%b", res_product, res_err);
          end
        end
        outstanding = 1'b0;
      end
    end else begin
      outstanding = 1'b0;
      done_prev   = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pair(input logic [A_W-1:0] a, input logic [A_W-1:0] b);
    logic acc;
    exp_t e;
    acc = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        e.err  = mul_hang;
        e.prod = mul_hang ? 8'd0 : {4'b0, a} * {4'b0, b};
        sb.push_back(e);
      end else begin
        stall_seen = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout: got in_ready=0 for 200 cycles, required acceptance of a=%0d b=%0d", a, b);
    end
  endtask

  task automatic wait_drained();
    int n;
    for (n = 0; n < 300; n++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    checks++;
    if (n == 300) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending results busy=%b, required 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mul_start, res_valid, busy, res_err} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got ready/start/valid/busy/err=%b required 10000",
               {in_ready, mul_start, res_valid, busy, res_err});
    end
    checks++;
    if ({mul_a, mul_b, res_product} !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: got a=%0d b=%0d product=%0d required 0", mul_a, mul_b, res_product);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int s0, n;
    res_ready = 1'b1;
    s0 = start_cnt;
    push_pair(4'd3, 4'd5);
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_t1: got start=%b busy=%b required start=0 busy=1", mul_start, busy);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b1) begin
      failures++;
      $display("FAIL latency_t2: got mul_start=%b required 1", mul_start);
    end
    for (n = 0; n < 50; n++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    checks++;
    if (res_valid !== 1'b1 || res_product !== 8'd15 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got valid=%b product=%0d err=%b required 1 15 0", res_valid, res_product, res_err);
    end
    tick();
    wait_drained();
    checks++;
    if (start_cnt - s0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_starts: got starts=%0d busy=%b required 1 and 0", start_cnt - s0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    res_ready = 1'b1;
    stall_seen = 1'b0;
    s0 = start_cnt;
    push_pair(4'd15, 4'd15);
    push_pair(4'd2, 4'd7);
    push_pair(4'd0, 4'd9);
    push_pair(4'd1, 4'd1);
    wait_drained();
    checks++;
    if (start_cnt - s0 != 4) begin
      failures++;
      $display("FAIL b2b_starts: got %0d required 4", start_cnt - s0);
    end
    checks++;
    if (stall_seen !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall: got in_ready never low with FIFO full, required a stall");
    end
  endtask

  task automatic test_backpressure();
    int s0, n;
    logic bad;
    res_ready = 1'b0;
    s0 = start_cnt;
    push_pair(4'd6, 4'd6);
    for (n = 0; n < 50; n++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    tick();
    push_pair(4'd1, 4'd2);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_product !== 8'd36 || res_err !== 1'b0 || mul_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL backpressure_hold: got valid=%b product=%0d start=%b required 1 36 0", res_valid, res_product, mul_start);
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL backpressure_starts: got %0d required 1", start_cnt - s0);
    end
    tick();
    res_ready = 1'b1;
    wait_drained();
  endtask

  task automatic test_timeout();
    int n;
    res_ready = 1'b0;
    mul_hang = 1'b1;
    push_pair(4'd5, 4'd5);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mul_start) break;
    end
    for (n = 1; n < 100; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    checks++;
    if (n != TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_cycles: got HOLD %0d cycles after launch, required %0d", n, TIMEOUT + 1);
    end
    checks++;
    if (res_err !== 1'b1 || res_product !== 8'd0) begin
      failures++;
      $display("FAIL timeout_result: got err=%b product=%0d required 1 0", res_err, res_product);
    end
    tick();
    mul_hang = 1'b0;
    res_ready = 1'b1;
    wait_drained();
    push_pair(4'd7, 4'd3);
    wait_drained();
  endtask

  task automatic test_spurious();
    res_ready = 1'b1;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0) begin
      failures++;
      $display("FAIL spur_idle: got valid=%b busy=%b start=%b required 0 0 0", res_valid, busy, mul_start);
    end
    tick();
    push_pair(4'd2, 4'd3);
    tick();
    spur_done = 1'b1;
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b1) begin
      failures++;
      $display("FAIL spur_launch_phase: got mul_start=%b required 1", mul_start);
    end
    tick();
    spur_done = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL spur_launch: got res_valid=%b required 0", res_valid);
    end
    tick();
    wait_drained();
  endtask

  task automatic test_reset_mid();
    logic bad;
    res_ready = 1'b0;
    mul_hang = 1'b1;
    push_pair(4'd1, 4'd1);
    push_pair(4'd2, 4'd2);
    push_pair(4'd3, 4'd3);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, mul_start, res_valid, busy, res_err} !== 5'b10000 ||
        {mul_a, mul_b, res_product} !== 16'h0) begin
      failures++;
      $display("FAIL reset_async: got ready/start/valid/busy/err=%b a=%0d b=%0d product=%0d required 10000 0 0 0",
               {in_ready, mul_start, res_valid, busy, res_err}, mul_a, mul_b, res_product);
    end
    sb.delete();
    mul_hang = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    res_ready = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mul_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_idle: got start or busy after reset release, required both 0");
    end
    tick();
    push_pair(4'd4, 4'd4);
    wait_drained();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d unreturned results required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
